load_store_unit: RTL and testbench

Bus initiator that turns CPU load/store requests into accesses on the data-memory bus (mem_addr / mem_sdata / mem_mask / mem_lenable / mem_ldata). It sits between the execute stage and the block-RAM data memory, and handles:
- byte-lane masking and store-data replication;
- the memory's registered read latency;
- load extraction with sign or zero extension;
- one-request-at-a-time handshaking back to the pipeline.

---
 rtl/load_store_unit_if.sv | 41 ++++
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundle of the LSU's request/response handshake and its data-memory bus.
// The 'slave' modport is the LSU itself; the 'master' modport is its
// environment (the pipeline issuing requests plus the memory returning data).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester keeps every req_* field stable
// until that edge. rsp_valid is a one-cycle pulse with no back-pressure.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        mem_lenable;
    logic [3:0]  mem_mask;
    logic [31:0] mem_ldata;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ldata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
        input  mem_addr, mem_sdata, mem_lenable, mem_mask
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ldata,
        output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
        output mem_addr, mem_sdata, mem_lenable, mem_mask
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU load/store request at a time into a
// byte-lane-masked access on a block-RAM data bus with registered read
// latency LOAD_LATENCY (legal 1..3), and returns sign/zero-extended loads.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are rejected with rsp_err instead of being
// silently aligned.
module load_store_unit #(
    parameter int LOAD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_q, addr_d;        // only the byte offset is needed after accept
    logic [4:0]  rd_q, rd_d;
    logic        err_q, err_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_sdata_q, mem_sdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;

    // Reserved width codes, signed-unsigned stores, and (optionally) misalignment.
    function automatic logic is_illegal(input logic st, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3[1:0] == 2'b01) && a[0])
            bad = 1'b1;
        if ((f3[1:0] == 2'b10) && (a != 2'b00))
            bad = 1'b1;
`else
        if (a == 2'b11)
            bad = bad;                  // offset does not affect legality
`endif
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Pick the addressed lane out of the returned word and extend it.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: return d;
        endcase
    endfunction

    // State and datapath registers; reset aborts any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 2'b00;
            rd_q        <= 5'd0;
            err_q       <= 1'b0;
            cnt_q       <= 2'd0;
            mem_addr_q  <= 32'h0;
            mem_sdata_q <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_rd_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_sdata_q <= mem_sdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    // Next-state and strobe logic. The store mask is deliberately not gated
    // by rst: a store already in ACCESS still presents its write at that edge.
    always_comb begin
        state_d         = state_q;
        store_d         = store_q;
        funct3_d        = funct3_q;
        addr_d          = addr_q;
        rd_d            = rd_q;
        err_d           = err_q;
        cnt_d           = cnt_q;
        mem_addr_d      = mem_addr_q;
        mem_sdata_d     = mem_sdata_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_rd_d        = rsp_rd_q;
        bus.req_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_err     = 1'b0;
        bus.mem_mask    = 4'b0000;
        bus.mem_lenable = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid && !rst) begin
                    store_d  = bus.req_store;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr[1:0];
                    rd_d     = bus.req_rd;
                    if (is_illegal(bus.req_store, bus.req_funct3, bus.req_addr[1:0])) begin
                        err_d       = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_rd_d    = bus.req_rd;
                        state_d     = DONE;
                    end else begin
                        err_d      = 1'b0;
                        mem_addr_d = {bus.req_addr[31:2], 2'b00};
                        if (bus.req_store)
                            mem_sdata_d = lane_data(bus.req_funct3, bus.req_wdata);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (store_q) begin
                    bus.mem_mask = lane_mask(funct3_q, addr_q);
                    rsp_rdata_d  = 32'h0;
                    rsp_rd_d     = rd_q;
                    state_d      = DONE;
                end else begin
                    bus.mem_lenable = !rst;
                    cnt_d           = 2'(LOAD_LATENCY);
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd1) begin
                    rsp_rdata_d = extract(funct3_q, addr_q, bus.mem_ldata);
                    rsp_rd_d    = rd_q;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                bus.rsp_valid = !rst;
                bus.rsp_err   = err_q && !rst;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_sdata = mem_sdata_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: lane 0 is a LOAD_LATENCY=1 instance, lane 1 a
// LOAD_LATENCY=3 instance; only one lane is exercised at a time so both share
// the expected-response and expected-bus-event queues.
module tb_load_store_unit;

    localparam int RW = 70;    // {cycle[31:0], err, rd[4:0], rdata[31:0]}
    localparam int BW = 101;   // {cycle[31:0], is_load, mask[3:0], addr[31:0], sdata[31:0]}

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [RW-1:0] rsp_q [$];
    logic [BW-1:0] bus_q [$];

    logic        req_valid_a  [2];
    logic        req_store_a  [2];
    logic [2:0]  req_funct3_a [2];
    logic [31:0] req_addr_a   [2];
    logic [31:0] req_wdata_a  [2];
    logic [4:0]  req_rd_a     [2];
    logic [31:0] mem_ldata_a  [2];

    wire         rdy_a       [2];
    wire         rsp_valid_a [2];
    wire [31:0]  rsp_rdata_a [2];
    wire [4:0]   rsp_rd_a    [2];
    wire         rsp_err_a   [2];
    wire [31:0]  maddr_a     [2];
    wire [31:0]  msdata_a    [2];
    wire         mlen_a      [2];
    wire [3:0]   mmask_a     [2];
    wire [1:0]   state_a     [2];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT lanes ----------------
    for (genvar g = 0; g < 2; g++) begin : g_lane
        load_store_unit_if bus ();
        assign bus.req_valid  = req_valid_a[g];
        assign bus.req_store  = req_store_a[g];
        assign bus.req_funct3 = req_funct3_a[g];
        assign bus.req_addr   = req_addr_a[g];
        assign bus.req_wdata  = req_wdata_a[g];
        assign bus.req_rd     = req_rd_a[g];
        assign bus.mem_ldata  = mem_ldata_a[g];
        assign rdy_a[g]       = bus.req_ready;
        assign rsp_valid_a[g] = bus.rsp_valid;
        assign rsp_rdata_a[g] = bus.rsp_rdata;
        assign rsp_rd_a[g]    = bus.rsp_rd;
        assign rsp_err_a[g]   = bus.rsp_err;
        assign maddr_a[g]     = bus.mem_addr;
        assign msdata_a[g]    = bus.mem_sdata;
        assign mlen_a[g]      = bus.mem_lenable;
        assign mmask_a[g]     = bus.mem_mask;

        load_store_unit #(.LOAD_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (bus),
            .state_o (state_a[g])
        );
    end

    // ---------------- memory model ----------------
    // Read data is valid only in the single cycle LOAD_LATENCY after the
    // strobe; any other cycle returns a poison word.
    logic [31:0] mem [64];
    logic [32:0] pipe [2][3];

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            for (int b = 0; b < 4; b++)
                if (mmask_a[l][b])
                    mem[maddr_a[l][7:2]][8*b +: 8] <= msdata_a[l][8*b +: 8];
            if (rst) begin
                pipe[l][0] <= 33'h0;
                pipe[l][1] <= 33'h0;
                pipe[l][2] <= 33'h0;
            end else begin
                pipe[l][0] <= {mlen_a[l], mem[maddr_a[l][7:2]]};
                pipe[l][1] <= pipe[l][0];
                pipe[l][2] <= pipe[l][1];
            end
        end
    end

    always_comb begin
        mem_ldata_a[0] = pipe[0][0][32] ? pipe[0][0][31:0] : 32'hBAD0_BAD0;
        mem_ldata_a[1] = pipe[1][2][32] ? pipe[1][2][31:0] : 32'hBAD0_BAD0;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [RW-1:0] er;
        logic [BW-1:0] eb;
        for (int l = 0; l < 2; l++) begin
            if (rsp_valid_a[l]) begin
                if (rsp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: lane %0d rsp_valid in cycle %0d, required none", l, cyc);
                end else begin
                    er = rsp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(er[69:38]));
                    check("rsp_err", 64'(rsp_err_a[l]), 64'(er[37]));
                    check("rsp_rd", 64'(rsp_rd_a[l]), 64'(er[36:32]));
                    check("rsp_rdata", 64'(rsp_rdata_a[l]), 64'(er[31:0]));
                end
            end
            if (mmask_a[l] != 4'b0000 || mlen_a[l]) begin
                if (bus_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL bus_unexpected: lane %0d mask 0x%0h lenable %0d in cycle %0d, required none",
                             l, mmask_a[l], mlen_a[l], cyc);
                end else begin
                    eb = bus_q.pop_front();
                    check("bus_cycle", 64'(cyc), 64'(eb[100:69]));
                    check("bus_lenable", 64'(mlen_a[l]), 64'(eb[68]));
                    check("bus_mask", 64'(mmask_a[l]), 64'(eb[67:64]));
                    check("bus_addr", 64'(maddr_a[l]), 64'(eb[63:32]));
                    if (!eb[68])
                        check("bus_sdata", 64'(msdata_a[l]), 64'(eb[31:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    // acc is the cycle index right after acceptance (the ACCESS/error cycle).
    task automatic issue(input int l, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input logic [3:0] exp_mask, input logic [31:0] exp_sdata,
                         input logic exp_rsp, input logic keep, output int acc);
        int t;
        int lat;
        logic [31:0] c_acc;
        logic [31:0] c_rsp;
        lat = (l == 0) ? 1 : 3;
        req_valid_a[l]  = 1'b1;
        req_store_a[l]  = st;
        req_funct3_a[l] = f3;
        req_addr_a[l]   = a;
        req_wdata_a[l]  = wd;
        req_rd_a[l]     = rd;
        t = 0;
        while (!rdy_a[l] && t < 40) begin
            @(negedge clk);
            t++;
        end
        acc = cyc + 1;
        if (!rdy_a[l]) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: lane %0d req_ready low for %0d cycles, required high", l, t);
            req_valid_a[l] = 1'b0;
        end else begin
            c_acc = 32'(acc);
            c_rsp = exp_err ? c_acc : (st ? c_acc + 32'd1 : c_acc + 32'd1 + 32'(lat));
            if (exp_rsp)
                rsp_q.push_back({c_rsp, exp_err, rd, (exp_err || st) ? 32'h0 : exp_rdata});
            if (!exp_err)
                bus_q.push_back({c_acc, !st, st ? exp_mask : 4'b0000, {a[31:2], 2'b00}, exp_sdata});
            @(negedge clk);
            if (!keep)
                req_valid_a[l] = 1'b0;
        end
    endtask

    task automatic st_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [3:0] m, input logic [31:0] sd);
        int acc;
        issue(0, 1'b1, f3, a, wd, rd, 1'b0, 32'h0, m, sd, 1'b1, 1'b0, acc);
    endtask

    task automatic ld_req(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] exp);
        int acc;
        issue(0, 1'b0, f3, a, 32'h0, rd, 1'b0, exp, 4'b0000, 32'h0, 1'b1, 1'b0, acc);
    endtask

    task automatic bad_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd);
        int acc;
        issue(0, st, f3, a, 32'h1234_5678, rd, 1'b1, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, acc);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(rdy_a[0]), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid_a[0]), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err_a[0]), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata_a[0]), 64'd0);
        check({tag, "_rsp_rd"}, 64'(rsp_rd_a[0]), 64'd0);
        check({tag, "_mem_addr"}, 64'(maddr_a[0]), 64'd0);
        check({tag, "_mem_sdata"}, 64'(msdata_a[0]), 64'd0);
        check({tag, "_mem_mask"}, 64'(mmask_a[0]), 64'd0);
        check({tag, "_mem_lenable"}, 64'(mlen_a[0]), 64'd0);
        check({tag, "_state"}, 64'(state_a[0]), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int acc1;
        int acc2;
        int t;
        for (int l = 0; l < 2; l++) begin
            req_valid_a[l]  = 1'b0;
            req_store_a[l]  = 1'b0;
            req_funct3_a[l] = 3'b000;
            req_addr_a[l]   = 32'h0;
            req_wdata_a[l]  = 32'h0;
            req_rd_a[l]     = 5'd0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_ready_lane1", 64'(rdy_a[1]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(rdy_a[0]), 64'd1);
        check("ready_after_reset_lane1", 64'(rdy_a[1]), 64'd1);

        // word store / load round trip
        st_req(F_W, 32'h10, 32'hDEAD_BEEF, 5'd1, 4'b1111, 32'hDEAD_BEEF);
        ld_req(F_W, 32'h10, 5'd2, 32'hDEAD_BEEF);
        // byte lanes: word 0x10 becomes 0xA5ADBEEF
        st_req(F_B, 32'h13, 32'h0000_00A5, 5'd3, 4'b1000, 32'hA5A5_A5A5);
        ld_req(F_B, 32'h13, 5'd4, 32'hFFFF_FFA5);
        ld_req(F_BU, 32'h13, 5'd5, 32'h0000_00A5);
        ld_req(F_B, 32'h11, 5'd6, 32'hFFFF_FFBE);
        ld_req(F_HU, 32'h10, 5'd7, 32'h0000_BEEF);
        ld_req(F_H, 32'h12, 5'd8, 32'hFFFF_A5AD);
        // halfword lanes: word 0x20 becomes 0x80011234
        st_req(F_H, 32'h22, 32'h0000_8001, 5'd9, 4'b1100, 32'h8001_8001);
        ld_req(F_H, 32'h22, 5'd10, 32'hFFFF_8001);
        ld_req(F_HU, 32'h22, 5'd11, 32'h0000_8001);
        st_req(F_H, 32'h20, 32'h5A5A_1234, 5'd12, 4'b0011, 32'h1234_1234);
        ld_req(F_W, 32'h20, 5'd13, 32'h8001_1234);
        // byte 1 of word 0x20: becomes 0x80017F34
        st_req(F_B, 32'h21, 32'h0000_007F, 5'd14, 4'b0010, 32'h7F7F_7F7F);
`ifdef LSU_MISALIGN_TRAP_EN
        bad_req(1'b0, F_W, 32'h21, 5'd16);
        bad_req(1'b0, F_H, 32'h23, 5'd17);
`else
        ld_req(F_W, 32'h21, 5'd16, 32'h8001_7F34);
        ld_req(F_H, 32'h23, 5'd17, 32'hFFFF_8001);
`endif
        ld_req(F_BU, 32'h21, 5'd15, 32'h0000_007F);

        // reset during WAIT of a load: no response, everything cleared
        issue(0, 1'b0, F_W, 32'h10, 32'h0, 5'd22, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, acc);
        @(negedge clk);
        check("abort_in_wait", 64'(state_a[0]), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 64'(rdy_a[0]), 64'd1);

        // illegal requests: error in the cycle after accept, no bus activity
        bad_req(1'b0, 3'b011, 32'h10, 5'd19);
        bad_req(1'b1, F_BU, 32'h10, 5'd20);
        bad_req(1'b0, 3'b111, 32'h14, 5'd21);
        ld_req(F_W, 32'h10, 5'd18, 32'hA5AD_BEEF);

        // latency-3 lane with req_valid held through the busy period
        issue(1, 1'b0, F_W, 32'h10, 32'h0, 5'd23, 1'b0, 32'hA5AD_BEEF, 4'b0000, 32'h0, 1'b1, 1'b1, acc1);
        issue(1, 1'b0, F_B, 32'h13, 32'h0, 5'd24, 1'b0, 32'hFFFF_FFA5, 4'b0000, 32'h0, 1'b1, 1'b0, acc2);
        check("b2b_accept_cycle", 64'(acc2), 64'(acc1 + 6));

        t = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
